// File: rtl/nor_bist_2_12.sv
// Self-test sequencer for a WIDTH-bit two-input NOR stage: sweeps every operand pair,
// counts mismatches against ~(a|b), captures the first failing pair and reports pass/fail.
module nor_bist_2_12 #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] in_data1,
  output logic [WIDTH-1:0] in_data2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] error_count,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [WIDTH-1:0] OP_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    settle, settle_nxt;
  logic [WIDTH-1:0] in_data1_nxt, in_data2_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [CNT_W-1:0] error_count_nxt;
  logic             first_fail_valid_nxt;
  logic [WIDTH-1:0] first_fail_a_nxt, first_fail_b_nxt;
  logic             mismatch;

  assign mismatch = (out_data != ~(in_data1 | in_data2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      settle           <= '0;
      in_data1         <= '0;
      in_data2         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      error_count      <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
    end else begin
      state            <= state_nxt;
      settle           <= settle_nxt;
      in_data1         <= in_data1_nxt;
      in_data2         <= in_data2_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      pass             <= pass_nxt;
      error_count      <= error_count_nxt;
      first_fail_valid <= first_fail_valid_nxt;
      first_fail_a     <= first_fail_a_nxt;
      first_fail_b     <= first_fail_b_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    settle_nxt           = settle;
    in_data1_nxt         = in_data1;
    in_data2_nxt         = in_data2;
    busy_nxt             = busy;
    done_nxt             = 1'b0;
    pass_nxt             = pass;
    error_count_nxt      = error_count;
    first_fail_valid_nxt = first_fail_valid;
    first_fail_a_nxt     = first_fail_a;
    first_fail_b_nxt     = first_fail_b;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt            = DRIVE;
          settle_nxt           = '0;
          in_data1_nxt         = '0;
          in_data2_nxt         = '0;
          error_count_nxt      = '0;
          pass_nxt             = 1'b0;
          first_fail_valid_nxt = 1'b0;
          busy_nxt             = 1'b1;
        end
      end
      DRIVE: begin
        settle_nxt = settle + SW'(1);
        if (settle == SETTLE_LAST) state_nxt = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          if (error_count != CNT_MAX) error_count_nxt = error_count + CNT_W'(1);
          if (!first_fail_valid) begin
            first_fail_valid_nxt = 1'b1;
            first_fail_a_nxt     = in_data1;
            first_fail_b_nxt     = in_data2;
          end
        end
        settle_nxt = '0;
        if (in_data2 != OP_MAX) begin
          in_data2_nxt = in_data2 + WIDTH'(1);
          state_nxt    = DRIVE;
        end else begin
          in_data2_nxt = '0;
          if (in_data1 != OP_MAX) begin
            in_data1_nxt = in_data1 + WIDTH'(1);
            state_nxt    = DRIVE;
          end else begin
            // last pair: verdict uses the count including this final compare
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            pass_nxt  = (error_count_nxt == '0);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nor_bist_2_12.sv
// Directed bench for nor_bist_2_12: a default instance and a CNT_W=4/SETTLE=3 instance.
module tb_nor_bist_2_12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   fault = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  out0, a0, b0, ffa0, ffb0;
  logic        busy0, done0, pass0, ffv0;
  logic [15:0] ec0;

  logic [3:0]  out1, a1, b1, ffa1, ffb1;
  logic        busy1, done1, pass1, ffv1;
  logic [3:0]  ec1;

  always #5 clk = ~clk;

  // NOR stage models: 0 good, 1 bit0 stuck at 0, 2 fully inverted
  always_comb begin
    out0 = ~(a0 | b0);
    if (fault == 1) out0[0] = 1'b0;
    else if (fault == 2) out0 = a0 | b0;
  end
  assign out1 = a1 | b1;

  nor_bist_2_12 dut0 (
    .clk(clk), .rst(rst), .start(start0), .out_data(out0),
    .in_data1(a0), .in_data2(b0), .busy(busy0), .done(done0), .pass(pass0),
    .error_count(ec0), .first_fail_valid(ffv0), .first_fail_a(ffa0), .first_fail_b(ffb0)
  );

  nor_bist_2_12 #(.WIDTH(4), .SETTLE(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .out_data(out1),
    .in_data1(a1), .in_data2(b1), .busy(busy1), .done(done1), .pass(pass1),
    .error_count(ec1), .first_fail_valid(ffv1), .first_fail_a(ffa1), .first_fail_b(ffb1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses start, then watches done for max_edges edges after the sampling edge.
  task automatic run_sweep(input bit sel, input int max_edges, input bit repulse,
                           output int first_done, output int ndone);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    start1 = 1'b0;
    first_done = -1;
    ndone = 0;
    for (int k = 1; k <= max_edges; k++) begin
      if (repulse && (k == 10 || k == 300)) start0 = 1'b1;
      step(1);
      start0 = 1'b0;
      if (sel ? done1 : done0) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
    end
  endtask

  int fd, nd;

  initial begin
    // 1: reset
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_a0", {28'd0, a0}, 0);
    chk("rst_b0", {28'd0, b0}, 0);
    chk("rst_busy0", {31'd0, busy0}, 0);
    chk("rst_done0", {31'd0, done0}, 0);
    chk("rst_pass0", {31'd0, pass0}, 0);
    chk("rst_ec0", {16'd0, ec0}, 0);
    chk("rst_ffv0", {31'd0, ffv0}, 0);
    chk("rst_ff0", {24'd0, ffa0, ffb0}, 0);
    chk("rst_dut1", {13'd0, a1, b1, busy1, done1, pass1, ec1, ffv1, ffa1, ffb1}, 0);
    step(5);
    chk("idle_done0", {31'd0, done0}, 0);
    chk("idle_busy0", {31'd0, busy0}, 0);

    // 2: good NOR
    fault = 0;
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    chk("start_busy", {31'd0, busy0}, 1);
    chk("start_ops", {24'd0, a0, b0}, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    run_sweep(1'b0, 530, 1'b0, fd, nd);
    chk("good_done_edge", fd, 512);
    chk("good_ndone", nd, 1);
    chk("good_pass", {31'd0, pass0}, 1);
    chk("good_ec", {16'd0, ec0}, 0);
    chk("good_ffv", {31'd0, ffv0}, 0);
    chk("good_busy_after", {31'd0, busy0}, 0);

    // 3: bit0 stuck at 0
    fault = 1;
    run_sweep(1'b0, 530, 1'b0, fd, nd);
    chk("stuck_done_edge", fd, 512);
    chk("stuck_ec", {16'd0, ec0}, 64);
    chk("stuck_pass", {31'd0, pass0}, 0);
    chk("stuck_ffv", {31'd0, ffv0}, 1);
    chk("stuck_ffa", {28'd0, ffa0}, 0);
    chk("stuck_ffb", {28'd0, ffb0}, 0);
    step(5);
    chk("stuck_hold_ec", {16'd0, ec0}, 64);
    chk("stuck_hold_ffv", {31'd0, ffv0}, 1);

    // 4: start re-pulsed mid-sweep is ignored
    fault = 0;
    run_sweep(1'b0, 530, 1'b1, fd, nd);
    chk("repulse_done_edge", fd, 512);
    chk("repulse_ndone", nd, 1);
    chk("repulse_pass", {31'd0, pass0}, 1);

    // 5: reset during pair (6,4)
    fault = 0;
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    step(201);
    chk("mid_a", {28'd0, a0}, 6);
    chk("mid_b", {28'd0, b0}, 4);
    chk("mid_busy", {31'd0, busy0}, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_outs", {13'd0, a0, b0, busy0, done0, pass0, ffv0, ffa0, ffb0}, 0);
    chk("abort_ec", {16'd0, ec0}, 0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (done0) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_sweep(1'b0, 530, 1'b0, fd, nd);
    chk("fresh_done_edge", fd, 512);
    chk("fresh_pass", {31'd0, pass0}, 1);

    // 6: saturating counter, inverted NOR, SETTLE=3
    run_sweep(1'b1, 1040, 1'b0, fd, nd);
    chk("sat_done_edge", fd, 1024);
    chk("sat_ndone", nd, 1);
    chk("sat_ec", {28'd0, ec1}, 15);
    chk("sat_pass", {31'd0, pass1}, 0);
    chk("sat_ffv", {31'd0, ffv1}, 1);
    chk("sat_ff", {24'd0, ffa1, ffb1}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
